// File: rtl/dmem_responder.sv
// dmem_responder: word-array data memory that answers core load/store
// requests on the waitrequest / readdata_valid / readdata handshake after a
// fixed access latency. Stands in for the data cache between execute and
// writeback in simulation and small builds.
// Optional build macro DMEM_RANDSTALL_EN: adds 0..3 pseudo-random wait cycles
// per accepted access, drawn from an 8-bit LFSR.
module dmem_responder #(
  parameter int ADDR_W  = 10,  // word-address width, depth 2**ADDR_W
  parameter int LATENCY = 2,   // acceptance-to-response cycles, 1..15
  parameter int DATA_W  = 32   // fixed at 32, four byte lanes
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       p_addr,
  input  logic              p_read,
  input  logic              p_write,
  input  logic [DATA_W-1:0] p_writedata,
  input  logic [3:0]        p_byteenable,
  output logic              p_waitrequest,
  output logic [DATA_W-1:0] p_readdata,
  output logic              p_readdata_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

`ifdef DMEM_RANDSTALL_EN
  // Worst case is LATENCY-1 plus 3 extra wait cycles, which needs a fifth bit.
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  // Number of WAIT cycles between acceptance and the response/idle cycle.
  localparam logic [CNT_W-1:0] BASE_WAIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] widx;
  logic              accept;
  logic              acc_rd;
  logic              acc_wr;
  logic [CNT_W-1:0]  extra;
  logic [CNT_W-1:0]  wait_total;

  // Address bits outside the word index are ignored, so high addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p_addr[31:ADDR_W+2], p_addr[1:0]};

  assign widx   = p_addr[ADDR_W+1:2];
  // Requests are taken in IDLE and RESP; WAIT holds them off via waitrequest.
  assign accept = !rst && (state_q != S_WAIT) && (p_read || p_write);
  // A simultaneous read and write behaves as a plain write.
  assign acc_wr = accept && p_write;
  assign acc_rd = accept && p_read && !p_write;

`ifdef DMEM_RANDSTALL_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Free-running LFSR, reseeded on reset so stall patterns are repeatable.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign extra = {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};
`else
  assign extra = '0;
`endif

  assign wait_total = BASE_WAIT + extra;

  // Store commits at the acceptance edge, only on enabled byte lanes.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (p_byteenable[i]) mem_q[widx][8*i +: 8] <= p_writedata[8*i +: 8];
      end
    end
  end

  // Load data is captured at acceptance and held until the RESP cycle.
  always_ff @(posedge clk) begin
    if (acc_rd) rdata_q <= mem_q[widx];
  end

  // Control state register; memory and data register are left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Next state: accept from IDLE/RESP, count down WAIT, then respond or idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = rd_pend_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          rd_pend_d = acc_rd;
          if (wait_total != '0) begin
            state_d = S_WAIT;
            cnt_d   = wait_total - CNT_ONE;
          end else if (acc_rd) begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = rd_pend_q ? S_RESP : S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    p_waitrequest    = 1'b0;
    p_readdata_valid = 1'b0;
    p_readdata       = '0;
    busy             = (state_q != S_IDLE);
    case (state_q)
      S_WAIT: p_waitrequest = 1'b1;
      S_RESP: begin
        p_readdata_valid = 1'b1;
        p_readdata       = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=2 and one at LATENCY=1,
// a transaction-level model per instance checked every cycle, and directed
// literal expectations for the listed scenarios.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [31:0] addr_i [2];
  logic [31:0] wd_i   [2];
  logic [3:0]  be_i   [2];
  logic        wreq   [2];
  logic        vld    [2];
  logic        busy   [2];
  logic [31:0] rdata  [2];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  bit model_on = 1'b0;

  typedef struct {
    int          c;
    logic [31:0] d;
  } vrec_t;
  vrec_t vq[$];
  int    whi [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_W(10), .LATENCY(2), .DATA_W(32)) u_lat2 (
    .clk(clk), .rst(rst),
    .p_addr(addr_i[0]), .p_read(rd_i[0]), .p_write(wr_i[0]),
    .p_writedata(wd_i[0]), .p_byteenable(be_i[0]),
    .p_waitrequest(wreq[0]), .p_readdata(rdata[0]),
    .p_readdata_valid(vld[0]), .busy(busy[0])
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1), .DATA_W(32)) u_lat1 (
    .clk(clk), .rst(rst),
    .p_addr(addr_i[1]), .p_read(rd_i[1]), .p_write(wr_i[1]),
    .p_writedata(wd_i[1]), .p_byteenable(be_i[1]),
    .p_waitrequest(wreq[1]), .p_readdata(rdata[1]),
    .p_readdata_valid(vld[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Records every read response and every waitrequest-high cycle.
  always @(negedge clk) begin
    if (model_on) begin
      for (int g = 0; g < 2; g++) begin
        if (vld[g] === 1'b1) vq.push_back('{cyc, rdata[g]});
        if (wreq[g] === 1'b1) whi[g]++;
      end
    end
  end

  // Transaction model: an access accepted in cycle T occupies the slave until
  // T+L; cycles T+1..T+L-1 stall, and a read answers in cycle T+L.
  for (genvar g = 0; g < 2; g++) begin : g_mdl
    localparam int L = (g == 0) ? 2 : 1;
    logic [31:0] mm [1024];
    int nf   = 0;
    int wend = -1;
    int rc   = -1;
    int pt   = -1;
    logic [31:0] rexp = '0;

    always @(negedge clk) begin
      bit         acc;
      logic [9:0] ix;
      if (model_on) begin
        ix = addr_i[g][11:2];
`ifndef DMEM_RANDSTALL_EN
        chk("waitrequest", 32'(wreq[g]), 32'(cyc <= wend));
        chk("readdata_valid", 32'(vld[g]), 32'(cyc == rc));
        chk("readdata", rdata[g], (cyc == rc) ? rexp : 32'h0);
        chk("busy", 32'(busy[g]), 32'((cyc <= wend) || (cyc == rc)));
        acc = (cyc >= nf);
`else
        chk("valid_while_waiting", 32'(vld[g] & wreq[g]), 32'h0);
        if (vld[g]) begin
          chk("valid_expected", 32'(pt >= 0), 32'h1);
          chk("valid_window", 32'((cyc - pt >= L) && (cyc - pt <= L + 3)), 32'h1);
          chk("readdata", rdata[g], rexp);
          pt = -1;
        end else begin
          chk("readdata_idle", rdata[g], 32'h0);
        end
        if (pt >= 0 && cyc - pt > L + 3) begin
          chk("valid_timeout", 32'h0, 32'h1);
          pt = -1;
        end
        acc = (wreq[g] == 1'b0);
`endif
        if (rst) begin
          nf   = cyc + 1;
          wend = -1;
          rc   = -1;
          pt   = -1;
        end else if ((rd_i[g] || wr_i[g]) && acc) begin
          if (wr_i[g]) begin
            for (int i = 0; i < 4; i++)
              if (be_i[g][i]) mm[ix][8*i +: 8] = wd_i[g][8*i +: 8];
          end else begin
            rexp = mm[ix];
            rc   = cyc + L;
            pt   = cyc;
          end
          wend = cyc + L - 1;
          nf   = cyc + L;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int g = 0; g < 2; g++) begin
      rd_i[g] = 1'b0;
      wr_i[g] = 1'b0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request and holds it until waitrequest is low at a sample point.
  task automatic req(input int g, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, output int tacc);
    int n;
    n = 0;
    tacc = -1;
    rd_i[g] = rd;  wr_i[g] = wr;  addr_i[g] = a;  wd_i[g] = d;  be_i[g] = be;
    while (tacc < 0 && n < 40) begin
      @(negedge clk);
      if (wreq[g] == 1'b0) tacc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (tacc < 0) chk("req_accept_timeout", 32'h0, 32'h1);
    rd_i[g] = 1'b0;
    wr_i[g] = 1'b0;
  endtask

  task automatic wr_word(input int g, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    int t;
    req(g, 1'b0, 1'b1, a, d, be, t);
  endtask

  task automatic rd_word(input int g, input logic [31:0] a, output logic [31:0] d,
                         output int lat);
    int t;
    int base;
    base = vq.size();
    req(g, 1'b1, 1'b0, a, 32'h0, 4'h0, t);
    idle(8);
    chk("one_valid_pulse", 32'(vq.size() - base), 32'h1);
    if (vq.size() > base) begin
      d   = vq[base].d;
      lat = vq[base].c - t;
    end else begin
      d   = 32'hxxxx_xxxx;
      lat = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          lat;
    int          tw;
    int          tr;
    int          t1;
    int          t2;
    int          t3;
    int          base;
    int          w0;
    int unsigned op;
    logic [31:0] a;

    for (int g = 0; g < 2; g++) begin
      rd_i[g] = 1'b0;  wr_i[g] = 1'b0;  addr_i[g] = '0;  wd_i[g] = '0;  be_i[g] = '0;
    end

    // Reset: all outputs low on both instances.
    @(posedge clk);
    #1;
    model_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_waitrequest", 32'(wreq[g]), 32'h0);
      chk("reset_valid", 32'(vld[g]), 32'h0);
      chk("reset_readdata", rdata[g], 32'h0);
      chk("reset_busy", 32'(busy[g]), 32'h0);
    end
    @(posedge clk);
    #1;

    // Full write then read at LATENCY=2: read held one cycle, data two later.
    base = vq.size();
    req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, tw);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, tr);
    idle(6);
    chk("t1_pulses", 32'(vq.size() - base), 32'h1);
`ifndef DMEM_RANDSTALL_EN
    chk("t1_read_accept_delay", 32'(tr - tw), 32'd2);
    if (vq.size() > base) chk("t1_valid_latency", 32'(vq[base].c - tr), 32'd2);
`endif
    if (vq.size() > base) chk("t1_data", vq[base].d, 32'hDEADBEEF);

    // Partial write on lanes 0 and 2.
    wr_word(0, 32'h10, 32'h11223344, 4'b0101);
    rd_word(0, 32'h10, d, lat);
    chk("t2_partial_data", d, 32'hDE22BE44);

    // LATENCY=1: back-to-back reads answer on consecutive cycles.
    wr_word(1, 32'h0, 32'h1, 4'hF);
    wr_word(1, 32'h4, 32'h2, 4'hF);
    wr_word(1, 32'h8, 32'h3, 4'hF);
    base = vq.size();
    w0   = whi[1];
    req(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, t1);
    req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, t2);
    req(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, t3);
    idle(8);
    chk("t3_pulses", 32'(vq.size() - base), 32'd3);
`ifndef DMEM_RANDSTALL_EN
    chk("t3_waitrequest_high_cycles", 32'(whi[1] - w0), 32'h0);
    chk("t3_accept_gap_a", 32'(t2 - t1), 32'h1);
    chk("t3_accept_gap_b", 32'(t3 - t2), 32'h1);
`endif
    for (int i = 0; i < 3; i++) begin
      if (vq.size() > base + i) begin
        chk("t3_data", vq[base + i].d, 32'(i + 1));
`ifndef DMEM_RANDSTALL_EN
        chk("t3_valid_cycle", 32'(vq[base + i].c - t1), 32'(i + 1));
`endif
      end
    end

    // Read and write together act as a write; upper address bits alias.
    base = vq.size();
    req(0, 1'b1, 1'b1, 32'h20, 32'h5, 4'hF, tw);
    idle(6);
    chk("t4_no_pulse_on_rw", 32'(vq.size() - base), 32'h0);
    rd_word(0, 32'h20, d, lat);
    chk("t4_rw_data", d, 32'h5);
    rd_word(0, 32'h20 + 32'(4 * 1024), d, lat);
    chk("t4_wrap_data", d, 32'h5);

    // Reset while the read is in WAIT: no pulse, outputs idle, memory kept.
    base = vq.size();
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, tr);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_waitrequest", 32'(wreq[0]), 32'h0);
    chk("t5_valid", 32'(vld[0]), 32'h0);
    chk("t5_readdata", rdata[0], 32'h0);
    chk("t5_busy", 32'(busy[0]), 32'h0);
    @(posedge clk);
    #1;
    idle(4);
    chk("t5_no_pulse", 32'(vq.size() - base), 32'h0);
    rd_word(0, 32'h10, d, lat);
    chk("t5_data_kept", d, 32'hDE22BE44);

    // Mixed random traffic, including back-to-back and aliased addresses.
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 16; k++) wr_word(g, 32'h100 + 32'(4 * k), $urandom, 4'hF);
      for (int n = 0; n < 100; n++) begin
        op = $urandom_range(0, 2);
        a  = (32'($urandom) & 32'hFFFF_F000) | (32'h100 + 32'(4 * $urandom_range(0, 15)))
             | 32'($urandom_range(0, 3));
        if (op == 0) wr_word(g, a, $urandom, 4'($urandom_range(0, 15)));
        else         req(g, 1'b1, 1'b0, a, 32'h0, 4'h0, tr);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave that answers core load/store requests on the cache-side handshake (waitrequest / readdata_valid / readdata).
- It is the responder consumed by the writeback stage: that stage treats `~p_waitrequest & p_readdata_valid` as load data returned.
- It holds a word array and inserts a fixed access latency.
- It sits between the execute stage's memory request and the writeback stage, standing in for the data cache in simulation and small builds.

Parameters:
- ADDR_W, 10, word-address width; array depth is 2**ADDR_W words.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.
- DATA_W, 32, data word width (fixed at 32; byte enables assume 4 lanes).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- p_addr  input  32  byte address; bits [ADDR_W+1:2] index the array, other bits ignored
- p_read  input  1  read request
- p_write  input  1  write request
- p_writedata  input  32  store data
- p_byteenable  input  4  per-byte write mask, bit i covers bits [8i+7:8i]
- p_waitrequest  output  1  high = request not accepted / access in progress
- p_readdata  output  32  load data, valid only with p_readdata_valid
- p_readdata_valid  output  1  one-cycle pulse carrying read data
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - State goes to IDLE and the counter clears.
  - p_waitrequest=0, p_readdata_valid=0, p_readdata=0, busy=0.
  - Array contents are NOT cleared.
  - Reset mid-access aborts the access: no valid pulse. A write already committed at acceptance stays committed.
- FSM states: IDLE, WAIT, RESP.
- Acceptance: a request is accepted on a cycle where state is IDLE or RESP and (p_read | p_write)=1.
  - p_waitrequest is 0 in IDLE and RESP, and 1 in WAIT.
- Write accepted at cycle T:
  - Array word is updated at the T edge, only the enabled bytes; byteenable=0 leaves memory unchanged.
  - If LATENCY=1: the next state is IDLE.
  - Otherwise: WAIT for LATENCY-1 cycles (T+1..T+LATENCY-1), then IDLE at T+LATENCY.
  - Writes never produce a readdata_valid pulse.
- Read accepted at cycle T:
  - The array word is captured into the data register at the T edge.
  - WAIT for LATENCY-1 cycles, then RESP at T+LATENCY.
  - If LATENCY=1: RESP directly at T+1.
- RESP cycle: p_readdata_valid=1, p_readdata = captured word, p_waitrequest=0.
  - A new request in the RESP cycle is accepted (back-to-back); otherwise the next state is IDLE.
- Outside RESP: p_readdata_valid=0 and p_readdata=0.
- p_read & p_write both high: treated as a write, no read response.
- Requests presented while in WAIT are ignored. The requester must hold them until waitrequest drops.
- Read of an address written by the request accepted in the immediately preceding cycle returns the new data (the write commits before the read capture edge).
- WAIT counter: 4 bits, loaded with LATENCY-2 on entry, decrements to 0, then exits WAIT.
- Address wrap: upper address bits are ignored, so address 4*2**ADDR_W aliases word 0.
- busy = (state != IDLE).

Optional Feature:
- Macro: DMEM_RANDSTALL_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (polynomial x^8+x^6+x^5+x^4+1) is seeded to 8'hA5 on reset and advances every cycle.
  - At each acceptance, lfsr[1:0] is added to the WAIT count, giving 0..3 extra wait cycles.
  - Even with LATENCY=1, an extra count >0 forces entry to WAIT.
- When not defined: no LFSR logic; latency is exactly LATENCY.

Test Plan:
1. Reset with LATENCY=2 → all outputs 0. Write 32'hDEADBEEF with be=4'hF to addr 32'h10 at T, then read addr 32'h10 at T+2 → p_waitrequest=1 at T+3, p_readdata_valid=1 and p_readdata=32'hDEADBEEF at T+4.
2. Partial write to addr 32'h10 with be=4'b0101, data 32'h11223344, after test 1 → read returns 32'hDE22BE44.
3. LATENCY=1, reads every cycle at addrs 0,4,8 preloaded 1,2,3 → p_waitrequest never high; valid pulses on 3 consecutive cycles with data 1,2,3.
4. p_read=p_write=1 at addr 32'h20 with data 32'h5 → no valid pulse; later read of 32'h20 returns 32'h5. Read of 32'h20 + 4*2**ADDR_W also returns 32'h5 (wrap).
5. Read accepted, rst asserted one cycle later while in WAIT → no valid pulse, all outputs 0 the cycle after reset; prior array data intact on re-read.
6. DMEM_RANDSTALL_EN defined, 100 random reads → each valid arrives LATENCY..LATENCY+3 cycles after acceptance; data always matches the scoreboard.
